// File: rtl/aoc_day1_dial_sequencer_pkg.sv
// rtl/aoc_day1_dial_sequencer_pkg.sv - shared state encoding and dial constants
package aoc_day1_dial_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  localparam logic [7:0] DIAL_START         = 8'd50;
  localparam int         DIAL_MOD           = 100;
  localparam int         DP_LATENCY_DEFAULT = 6;

endpackage

// File: rtl/aoc_day1_dial_sequencer_if.sv
// rtl/aoc_day1_dial_sequencer_if.sv - rotation command stream from the input parser
interface aoc_day1_dial_sequencer_if #(
  parameter int AMT_W = 32
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir_r;
  logic [AMT_W-1:0] cmd_amount;
  logic             cmd_last;

  // Parser side: produces commands, observes back-pressure.
  modport master (
    output cmd_valid,
    output cmd_dir_r,
    output cmd_amount,
    output cmd_last,
    input  cmd_ready
  );

  // Sequencer side: consumes commands, drives back-pressure.
  modport slave (
    input  cmd_valid,
    input  cmd_dir_r,
    input  cmd_amount,
    input  cmd_last,
    output cmd_ready
  );

endinterface

// File: rtl/aoc_day1_issue_tracker.sv
// rtl/aoc_day1_issue_tracker.sv - valid delay line marking which dp_pos samples belong to real commands
module aoc_day1_issue_tracker #(
  parameter int DEPTH = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic push,
  output logic retire,
  output logic empty
);

  logic [DEPTH-1:0] vld;

  // One bit shifts in every cycle: 1 for an issued command, 0 for a no-op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else if (clear) begin
      vld <= '0;
    end else begin
      vld <= {vld[DEPTH-2:0], push};
    end
  end

  assign retire = vld[DEPTH-1];
  // Nothing remains in flight once the entry retiring this cycle has left.
  assign empty  = ~|vld[DEPTH-2:0];

endmodule

// File: rtl/aoc_day1_dial_sequencer.sv
// rtl/aoc_day1_dial_sequencer.sv - issues rotation commands into the dial datapath and counts zero landings
module aoc_day1_dial_sequencer
  import aoc_day1_dial_sequencer_pkg::*;
#(
  parameter int DP_LATENCY = DP_LATENCY_DEFAULT,
  parameter int AMT_W      = 32,
  parameter int CNT_W      = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  aoc_day1_dial_sequencer_if.slave        cmd_if,
  output logic                            dp_rst,
  output logic [AMT_W-1:0]                dp_in_data,
  output logic                            dp_dir_r,
  input  logic [7:0]                      dp_pos,
  output logic                            busy,
  output logic                            done,
  output logic [CNT_W-1:0]                zero_count,
  output logic [CNT_W-1:0]                cmd_count,
  output logic [7:0]                      final_pos
);

  seq_state_t state, next_state;
  logic       cmd_ready_c;
  logic       clear_run;
  logic       hs;
  logic       retire;
  logic       trk_empty;

  assign cmd_if.cmd_ready = cmd_ready_c;
  assign hs               = cmd_ready_c & cmd_if.cmd_valid;

  aoc_day1_issue_tracker #(
    .DEPTH (DP_LATENCY)
  ) u_tracker (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear_run),
    .push   (hs),
    .retire (retire),
    .empty  (trk_empty)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and state-derived control outputs.
  always_comb begin
    next_state  = state;
    cmd_ready_c = 1'b0;
    dp_rst      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    clear_run   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) next_state = ST_CLEAR;
      end
      ST_CLEAR: begin
        dp_rst     = 1'b1;
        busy       = 1'b1;
        clear_run  = 1'b1;
        next_state = ST_RUN;
      end
      ST_RUN: begin
        busy        = 1'b1;
        cmd_ready_c = 1'b1;
        if (cmd_if.cmd_valid && cmd_if.cmd_last) next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (trk_empty) next_state = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) next_state = ST_CLEAR;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Issue register: accepted command or the no-op (right by 0) every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_in_data <= '0;
      dp_dir_r   <= 1'b1;
    end else if (hs) begin
      dp_in_data <= cmd_if.cmd_amount;
      dp_dir_r   <= cmd_if.cmd_dir_r;
    end else begin
      dp_in_data <= '0;
      dp_dir_r   <= 1'b1;
    end
  end

  // Result counters: accepted commands and retired landings on zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_count <= '0;
      cmd_count  <= '0;
      final_pos  <= DIAL_START;
    end else if (clear_run) begin
      zero_count <= '0;
      cmd_count  <= '0;
      final_pos  <= DIAL_START;
    end else begin
      if (hs) cmd_count <= cmd_count + CNT_W'(1);
      if (retire) begin
        final_pos <= dp_pos;
        if (dp_pos == 8'd0) zero_count <= zero_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_aoc_day1_dial_sequencer.sv
// tb/tb_aoc_day1_dial_sequencer.sv - directed bench with a behavioural dial datapath
module tb_aoc_day1_dial_sequencer;
  import aoc_day1_dial_sequencer_pkg::*;

  localparam int LAT   = 6;
  localparam int AMT_W = 32;
  localparam int CNT_W = 32;
  localparam int PD    = LAT - 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             dp_rst;
  logic [AMT_W-1:0] dp_in_data;
  logic             dp_dir_r;
  logic [7:0]       dp_pos;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] zero_count;
  logic [CNT_W-1:0] cmd_count;
  logic [7:0]       final_pos;

  int n_checks = 0;
  int n_fail   = 0;

  bit          dirs[$];
  int unsigned amts[$];
  int          gaps[$];

  aoc_day1_dial_sequencer_if #(.AMT_W(AMT_W)) cmd_if ();

  aoc_day1_dial_sequencer #(
    .DP_LATENCY (LAT),
    .AMT_W      (AMT_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cmd_if     (cmd_if.slave),
    .dp_rst     (dp_rst),
    .dp_in_data (dp_in_data),
    .dp_dir_r   (dp_dir_r),
    .dp_pos     (dp_pos),
    .busy       (busy),
    .done       (done),
    .zero_count (zero_count),
    .cmd_count  (cmd_count),
    .final_pos  (final_pos)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: dp_pos reflects a command LAT cycles after it was registered.
  logic [AMT_W:0] pipe [0:PD-1];
  int             dial;

  function automatic int step(input int d, input logic [AMT_W:0] e);
    int r;
    r = int'(e[AMT_W-1:0] % 32'd100);
    return e[AMT_W] ? (d + r) % DIAL_MOD : (d + DIAL_MOD - r) % DIAL_MOD;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst || dp_rst) begin
      dial <= 50;
      for (int i = 0; i < PD; i++) pipe[i] <= '0;
    end else begin
      dial <= step(dial, pipe[PD-1]);
      for (int i = PD - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= {dp_dir_r, dp_in_data};
    end
  end

  assign dp_pos = 8'(dial);

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic pulse_start(output logic rst_a, output logic rst_b);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst_a = dp_rst;
    @(negedge clk);
    rst_b = dp_rst;
  endtask

  task automatic send(input bit dir, input int unsigned amt, input bit last);
    int n;
    n = 0;
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_dir_r  = dir;
    cmd_if.cmd_amount = amt;
    cmd_if.cmd_last   = last;
    while (!cmd_if.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_timeout", 0, 1);
    @(negedge clk);
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_last   = 1'b0;
    cmd_if.cmd_amount = '0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic run_stream(output int drain);
    logic a, b;
    pulse_start(a, b);
    for (int i = 0; i < dirs.size(); i++) begin
      send(dirs[i], amts[i], i == dirs.size() - 1);
      for (int g = 0; g < gaps[i]; g++) @(negedge clk);
    end
    wait_done(drain);
  endtask

  task automatic load_puzzle(input bit with_gaps);
    dirs = '{0, 0, 1, 0, 1, 0, 0, 0, 1, 0};
    amts = '{68, 30, 48, 5, 60, 55, 1, 99, 14, 82};
    gaps.delete();
    for (int i = 0; i < 10; i++) begin
      if (!with_gaps) gaps.push_back(0);
      else if (i == 2) gaps.push_back(5);
      else if (i == 9) gaps.push_back(0);
      else gaps.push_back(int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    int   drain;
    logic ra, rb;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_dir_r  = 1'b0;
    cmd_if.cmd_amount = '0;
    cmd_if.cmd_last   = 1'b0;

    // 1. reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_final_pos", final_pos, 50);
    check("idle_cmd_ready", cmd_if.cmd_ready, 0);
    check("idle_zero_count", zero_count, 0);
    check("idle_cmd_count", cmd_count, 0);
    check("idle_dp_dir_r", dp_dir_r, 1);
    check("idle_dp_in_data", dp_in_data, 0);

    // 2. puzzle example back-to-back
    load_puzzle(1'b0);
    run_stream(drain);
    check("puzzle_zero_count", zero_count, 3);
    check("puzzle_final_pos", final_pos, 32);
    check("puzzle_cmd_count", cmd_count, 10);
    check("puzzle_drain_cycles", drain, LAT);
    check("puzzle_busy_in_done", busy, 0);

    // 5. restart after done
    @(negedge clk);
    check("done_held", done, 1);
    dirs = '{1};
    amts = '{50};
    gaps = '{0};
    pulse_start(ra, rb);
    check("restart_dp_rst_clear", ra, 1);
    check("restart_dp_rst_pulse", rb, 0);
    check("restart_done_cleared", done, 0);
    send(1'b1, 50, 1'b1);
    wait_done(drain);
    check("restart_zero_count", zero_count, 1);
    check("restart_cmd_count", cmd_count, 1);
    check("restart_final_pos", final_pos, 0);

    // 3. puzzle with gaps, dial parked at 0 during idle cycles
    load_puzzle(1'b1);
    run_stream(drain);
    check("gaps_zero_count", zero_count, 3);
    check("gaps_final_pos", final_pos, 32);
    check("gaps_cmd_count", cmd_count, 10);

    // 4. large amounts
    dirs = '{1, 0};
    amts = '{1000, 250};
    gaps = '{0, 0};
    run_stream(drain);
    check("large_final_pos", final_pos, 0);
    check("large_zero_count", zero_count, 1);
    dirs = '{1};
    amts = '{32'hFFFF_FFFF};
    gaps = '{0};
    run_stream(drain);
    check("max_amt_final_pos", final_pos, 45);
    check("max_amt_zero_count", zero_count, 0);

    // 6. reset in the middle of a run
    pulse_start(ra, rb);
    send(0, 68, 0);
    send(0, 30, 0);
    send(1, 48, 0);
    send(0, 5, 0);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_cmd_ready", cmd_if.cmd_ready, 0);
    check("midrst_zero_count", zero_count, 0);
    check("midrst_cmd_count", cmd_count, 0);
    check("midrst_final_pos", final_pos, 50);
    check("midrst_dp_in_data", dp_in_data, 0);
    check("midrst_dp_dir_r", dp_dir_r, 1);
    @(negedge clk);
    rst = 1'b0;
    load_puzzle(1'b0);
    run_stream(drain);
    check("post_rst_zero_count", zero_count, 3);
    check("post_rst_final_pos", final_pos, 32);
    check("post_rst_cmd_count", cmd_count, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
